lc3_fetch_unit: RTL and testbench
=================================

// Module: lc3_fetch_unit
// PURPOSE
//  LC3 instruction fetch stage: owns the PC, issues reads to the instruction
//  memory responder (imemResp) and buffers returned instructions in a small FIFO.
//  Presents {instr, npc} to the decode stage over a valid/ready handshake.
//  Control/execute redirect it on a taken branch.
// PARAMETERS
//  PC_RESET   16'h3000  PC value after reset
//  BUF_DEPTH  2         instruction FIFO entries (>=1)
//  ADDR_W     16        PC/address width
//  INSTR_W    16        instruction width
// PORTS
//  clock        in   1        single clock, rising edge
//  reset        in   1        asynchronous, active-low reset
//  enable_fetch in   1        1 = new imem requests permitted (control stall when 0)
//  br_taken     in   1        redirect pulse; PC <- taddr
//  taddr        in   ADDR_W   redirect target
//  imem_req     out  1        one-cycle request strobe; always accepted by memory
//  imem_addr    out  ADDR_W   request address (valid when imem_req=1)
//  imem_rvalid  in   1        response strobe, in order, L>=1 cycles after request
//  imem_rdata   in   INSTR_W  response instruction
//  dout_valid   out  1        FIFO head valid
//  dout_instr   out  INSTR_W  head instruction
//  dout_npc     out  ADDR_W   head instruction address + 1
//  dout_ready   in   1        decode accepts head when valid&ready
//  err_spurious out  1        sticky: imem_rvalid seen with nothing outstanding
// BEHAVIOUR
//  - Reset (async assert, sync release): pc=PC_RESET, FIFO empty, state IDLE;
//    imem_req=0, imem_addr=PC_RESET, dout_valid=0, dout_instr=0, dout_npc=0, err_spurious=0.
//  - Max one outstanding request. Issue condition:
//    enable_fetch & !br_taken & (count + outstanding < BUF_DEPTH).
//  - FSM: IDLE -> WAIT when request issued. WAIT + rvalid: push {rdata, req_pc+1};
//    issue again in same cycle if condition holds (stay WAIT), else IDLE.
//    WAIT + br_taken (no rvalid same cycle) -> DROP. DROP + rvalid: discard, -> IDLE.
//  - Throughput: one instruction per L cycles (back-to-back issue on rvalid cycle).
//  - On issue: imem_addr=pc, req_pc<=pc, pc<=pc+1 modulo 2^ADDR_W (16'hFFFF -> 16'h0000).
//  - br_taken has top priority: FIFO flushed, pc<=taddr, no issue that cycle;
//    a same-cycle pop is void; a same-cycle rvalid is discarded (-> IDLE, not DROP).
//    dout_valid=0 from next cycle; first post-redirect request next cycle at taddr.
//  - FIFO: registered outputs show head; push and pop in same cycle legal when full
//    or empty+push is not bypassed (pushed entry visible next cycle, 1-cycle latency).
//  - Push never occurs when full (guaranteed by issue condition).
//  - enable_fetch=0: no new issue; outstanding response still completes into FIFO.
//  - imem_rvalid in IDLE: ignored, err_spurious<=1 (cleared only by reset).
//  - Reset mid-operation: outstanding/DROP state discarded; return to IDLE.
// STRUCTURE
//  - lc3_fetch_pkg: fetch_state_e {IDLE, WAIT, DROP}; fetch_entry_t struct
//    {instr, npc}; PC_RESET_DEFAULT constant.
//  - Sub-module lc3_fetch_fifo: parameterised BUF_DEPTH FIFO of fetch_entry_t with
//    push, pop, flush, count, full, empty.
//  - Top: PC register, FSM, issue logic, error flag.
// TESTING
//  1. Reset, enable_fetch=1, L=1, ready=1 -> imem_addr 3000,3001,3002 on
//     successive requests; dout_npc 3001,3002,3003 in order.
//  2. ready=0, L=1 -> two entries buffered, imem_req stops at count=2; ready=1
//     -> next request at 3002, FIFO drains in order.
//  3. L=3, br_taken with taddr=4000 while request at 3001 outstanding -> its
//     response dropped; next imem_addr=4000; first dout_npc=4001.
//  4. br_taken with taddr=FFFF -> requests FFFF then 0000; dout_npc 0000 then 0001.
//  5. enable_fetch=0 after issue at 3000 -> response pushed (npc 3001), no new
//     request until enable_fetch=1; then issue at 3001.
//  6. reset asserted during WAIT -> outputs at reset values immediately; stray
//     rvalid in IDLE -> err_spurious=1 until next reset.

Source files
------------

// File: rtl/lc3_fetch_pkg.sv
// lc3_fetch_pkg: shared types and constants for the LC3 instruction fetch stage.
//   fetch_state_e    : fetch FSM states (IDLE / WAIT / DROP)
//   fetch_entry_t    : one buffered instruction {instr, npc}
//   PC_RESET_DEFAULT : PC value after reset
// Entry fields are 16 bits wide. The top-level ADDR_W/INSTR_W parameters
// must stay at 16 to match.
package lc3_fetch_pkg;

  localparam logic [15:0] PC_RESET_DEFAULT = 16'h3000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,   // no request outstanding
    WAIT = 2'd1,   // one request outstanding, response wanted
    DROP = 2'd2    // one request outstanding, response to be discarded
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] npc;
  } fetch_entry_t;

endpackage

// File: rtl/lc3_fetch_fifo.sv
// lc3_fetch_fifo: DEPTH-entry FIFO of fetch_entry_t.
//   clock, reset (async, active-low)
//   push/push_data : write an entry (caller never pushes when full)
//   pop            : drop the head (caller never pops when empty)
//   flush          : empty the FIFO; overrides push and pop
//   head           : current head entry (storage read, no bypass)
//   count/full/empty : occupancy
// A pushed entry becomes visible at the head on the next cycle at the earliest.
module lc3_fetch_fifo
  import lc3_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  input  logic               flush,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;

  // Pointer increment with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/lc3_fetch_unit.sv
// lc3_fetch_unit: LC3 instruction fetch stage.
//   clock, reset (async, active-low)
//   enable_fetch           : new imem requests permitted when 1
//   br_taken, taddr        : redirect pulse and target; flushes buffered work
//   imem_req, imem_addr    : one-cycle request strobe and address (addr = PC)
//   imem_rvalid, imem_rdata: in-order response, >=1 cycle after request
//   dout_valid/instr/npc   : FIFO head towards decode
//   dout_ready             : decode accepts head when dout_valid & dout_ready
//   err_spurious           : sticky, response seen with nothing outstanding
//   dbg_state              : fetch FSM state
// Handshake: an entry transfers on a cycle where dout_valid and dout_ready are
// both 1; dout_valid never depends on dout_ready, and the head holds until taken
// or flushed by a redirect.
module lc3_fetch_unit
  import lc3_fetch_pkg::*;
#(
  parameter int              ADDR_W    = 16,
  parameter int              INSTR_W   = 16,
  parameter logic [ADDR_W-1:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_fetch,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  taddr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dout_valid,
  output logic [INSTR_W-1:0] dout_instr,
  output logic [ADDR_W-1:0]  dout_npc,
  input  logic               dout_ready,
  output logic               err_spurious,
  output logic [1:0]         dbg_state
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_e       state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  req_pc;
  logic               run_q;     // 0 during reset and the first cycle after, gates imem_req
  logic               err_q;

  fetch_entry_t       push_entry;
  fetch_entry_t       head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  logic               pop;
  logic               push;
  logic               slot;
  logic [CNT_W:0]     occ;
  logic               issue;

  always_comb begin
    // A redirect voids the pop and discards any response arriving with it.
    pop  = !fifo_empty && dout_ready && !br_taken;
    push = (state == WAIT) && imem_rvalid && !br_taken;
    // Only one request may be in flight; a WAIT response frees the slot in
    // the same cycle so back-to-back issue is possible.
    slot = (state == IDLE) || ((state == WAIT) && imem_rvalid);
    // Occupancy after this cycle's pop/push, plus the request about to issue.
    occ  = {1'b0, fifo_count} - (CNT_W+1)'(pop) + (CNT_W+1)'(push);
    issue = run_q && enable_fetch && !br_taken && slot &&
            (occ < (CNT_W+1)'(BUF_DEPTH));
    push_entry.instr = imem_rdata;
    push_entry.npc   = req_pc + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pc     <= PC_RESET;
      req_pc <= PC_RESET;
      run_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (imem_rvalid && (state == IDLE)) err_q <= 1'b1;
      if (br_taken) begin
        pc <= taddr;
        // A response still in flight must be swallowed; one arriving now is
        // simply discarded.
        if ((state != IDLE) && !imem_rvalid) state <= DROP;
        else                                 state <= IDLE;
      end else begin
        case (state)
          IDLE:    if (issue) state <= WAIT;
          WAIT:    if (imem_rvalid) state <= issue ? WAIT : IDLE;
          DROP:    if (imem_rvalid) state <= IDLE;
          default: state <= IDLE;
        endcase
        if (issue) begin
          req_pc <= pc;
          pc     <= pc + 1'b1;
        end
      end
    end
  end

  lc3_fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (br_taken),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign imem_req     = issue;
  assign imem_addr    = pc;
  assign dout_valid   = !fifo_empty;
  assign dout_instr   = head.instr;
  assign dout_npc     = head.npc;
  assign err_spurious = err_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_lc3_fetch_unit.sv
module tb_lc3_fetch_unit;

  localparam int DEPTH = 2;

  // clock / reset
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  always #5 clock = ~clock;

  logic        enable_fetch = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] taddr = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        dout_valid;
  logic [15:0] dout_instr;
  logic [15:0] dout_npc;
  logic        dout_ready = 1'b0;
  logic        err_spurious;
  logic [1:0]  dbg_state;

  lc3_fetch_unit dut (
    .clock        (clock),
    .reset        (reset),
    .enable_fetch (enable_fetch),
    .br_taken     (br_taken),
    .taddr        (taddr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .dout_valid   (dout_valid),
    .dout_instr   (dout_instr),
    .dout_npc     (dout_npc),
    .dout_ready   (dout_ready),
    .err_spurious (err_spurious),
    .dbg_state    (dbg_state)
  );

  int checks = 0;
  int fails  = 0;

  // scoreboard: expected FIFO contents {instr, npc}, head first
  logic [31:0] exp_q[$];
  // reference model state
  logic [15:0] m_pc;
  logic [15:0] m_req_pc;
  bit          m_out, m_drop, m_err, m_run;

  // memory responder and logs
  int          resp_q[$];   // due cycle of each outstanding response
  int          cyc = 0;
  int          lat = 1;
  bit          stray = 1'b0;
  logic [15:0] addr_log[$];
  logic [15:0] npc_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] addr_at(input int i);
    return (i < addr_log.size()) ? addr_log[i] : 16'hDEAD;
  endfunction

  function automatic logic [15:0] npc_at(input int i);
    return (i < npc_log.size()) ? npc_log[i] : 16'hDEAD;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc = 16'h3000; m_req_pc = 16'h3000;
    m_out = 0; m_drop = 0; m_err = 0; m_run = 0;
    addr_log.delete(); npc_log.delete();
  endtask

  // Called shortly after a rising edge; asserts reset asynchronously, checks
  // outputs immediately, releases between edges.
  task automatic do_reset();
    reset = 1'b0;
    imem_rvalid = 1'b0;
    resp_q.delete();
    #1;
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, 16'h3000);
    chk("rst_dout_valid", dout_valid, 1'b0);
    chk("rst_dout_instr", dout_instr, 16'h0000);
    chk("rst_dout_npc", dout_npc, 16'h0000);
    chk("rst_err", err_spurious, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    @(posedge clock);
    #1;
    model_reset();
    reset = 1'b1;
  endtask

  // One clock cycle: drive response, check outputs against model, advance.
  task automatic cycle();
    bit pop, useful, slot, e_req, old_out, dut_req;
    int occ;
    logic [15:0] npc_new;
    if (stray) begin
      imem_rvalid = 1'b1; imem_rdata = 16'($urandom);
    end else if (resp_q.size() > 0 && resp_q[0] == cyc) begin
      imem_rvalid = 1'b1; imem_rdata = 16'($urandom);
      void'(resp_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
    end
    #2;
    pop    = (exp_q.size() > 0) && dout_ready && !br_taken;
    useful = imem_rvalid && m_out && !m_drop && !br_taken;
    slot   = !m_out || (imem_rvalid && !m_drop);
    occ    = exp_q.size() - int'(pop) + int'(useful);
    e_req  = m_run && enable_fetch && !br_taken && slot && (occ < DEPTH);
    chk("imem_req", imem_req, e_req);
    chk("imem_addr", imem_addr, m_pc);
    chk("dout_valid", dout_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk("dout_instr", dout_instr, exp_q[0][31:16]);
      chk("dout_npc", dout_npc, exp_q[0][15:0]);
    end
    chk("err_spurious", err_spurious, m_err);
    if (imem_req) addr_log.push_back(imem_addr);
    if (dout_valid && dout_ready && !br_taken) npc_log.push_back(dout_npc);
    dut_req = imem_req;
    @(posedge clock);
    old_out = m_out;
    if (br_taken) begin
      exp_q.delete();
      m_pc = taddr;
      if (m_out && !imem_rvalid) m_drop = 1;
      else begin m_out = 0; m_drop = 0; end
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (useful) begin
        npc_new = m_req_pc + 16'd1;
        exp_q.push_back({imem_rdata, npc_new});
      end
      if (imem_rvalid && m_out) begin m_out = 0; m_drop = 0; end
      if (e_req) begin m_out = 1; m_req_pc = m_pc; m_pc = m_pc + 16'd1; end
    end
    if (imem_rvalid && !old_out) m_err = 1;
    m_run = 1;
    if (dut_req) resp_q.push_back(cyc + lat);
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // initial reset
    #2;
    chk("por_imem_req", imem_req, 1'b0);
    chk("por_dout_valid", dout_valid, 1'b0);
    chk("por_err", err_spurious, 1'b0);
    @(posedge clock);
    #1;
    model_reset();
    reset = 1'b1;

    // 1: streaming with L=1
    enable_fetch = 1; dout_ready = 1; lat = 1;
    run(8);
    chk("t1_addr0", addr_at(0), 16'h3000);
    chk("t1_addr1", addr_at(1), 16'h3001);
    chk("t1_addr2", addr_at(2), 16'h3002);
    chk("t1_npc0", npc_at(0), 16'h3001);
    chk("t1_npc1", npc_at(1), 16'h3002);
    chk("t1_npc2", npc_at(2), 16'h3003);

    // 2: backpressure fills the buffer, then drain
    do_reset();
    enable_fetch = 1; dout_ready = 0; lat = 1;
    run(6);
    chk("t2_req_count", addr_log.size(), 2);
    chk("t2_full_valid", dout_valid, 1'b1);
    dout_ready = 1;
    run(6);
    chk("t2_addr2", addr_at(2), 16'h3002);
    chk("t2_npc0", npc_at(0), 16'h3001);
    chk("t2_npc1", npc_at(1), 16'h3002);
    chk("t2_npc2", npc_at(2), 16'h3003);

    // 3: redirect while 3001 is outstanding with L=3
    do_reset();
    enable_fetch = 1; dout_ready = 1; lat = 3;
    run(5);
    chk("t3_pre_addr1", addr_at(1), 16'h3001);
    br_taken = 1; taddr = 16'h4000;
    cycle();
    br_taken = 0;
    run(12);
    chk("t3_addr2", addr_at(2), 16'h4000);
    chk("t3_npc0", npc_at(0), 16'h4001);

    // 4: redirect to top of address space, PC wraps
    do_reset();
    enable_fetch = 1; dout_ready = 1; lat = 1;
    cycle();
    br_taken = 1; taddr = 16'hFFFF;
    cycle();
    br_taken = 0;
    run(6);
    chk("t4_addr0", addr_at(0), 16'hFFFF);
    chk("t4_addr1", addr_at(1), 16'h0000);
    chk("t4_npc0", npc_at(0), 16'h0000);
    chk("t4_npc1", npc_at(1), 16'h0001);

    // 5: fetch stall after the first issue
    do_reset();
    enable_fetch = 1; dout_ready = 0; lat = 2;
    run(2);
    enable_fetch = 0;
    run(6);
    chk("t5_req_count", addr_log.size(), 1);
    chk("t5_valid", dout_valid, 1'b1);
    chk("t5_npc", dout_npc, 16'h3001);
    enable_fetch = 1;
    cycle();
    chk("t5_addr1", addr_at(1), 16'h3001);

    // 6: reset during WAIT, then a stray response
    do_reset();
    enable_fetch = 1; dout_ready = 1; lat = 3;
    run(2);
    do_reset();
    enable_fetch = 0;
    stray = 1;
    cycle();
    stray = 0;
    run(4);
    chk("t6_err_sticky", err_spurious, 1'b1);
    do_reset();

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      enable_fetch = ($urandom_range(0, 9) != 0);
      dout_ready   = ($urandom_range(0, 3) != 0);
      br_taken     = ($urandom_range(0, 19) == 0);
      taddr        = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                                 : 16'($urandom);
      lat          = $urandom_range(1, 4);
      cycle();
    end
    br_taken = 0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  // Watchdog: any hang still ends in a FAIL line.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
